collision_probe: RTL and testbench



---
 rtl/level_pkg.sv | 58 +++++
 rtl/probe_addr_gen.sv | 53 +++++
 rtl/collision_probe.sv | 171 +++++++++++++++++
 tb/tb_collision_probe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// level_pkg: shared definitions for the level tile map and the collision probe.
//   - Tile-map geometry: ROW_MAX, COL_MAX, LEFT, TOP, TILE_SHIFT
//   - probe_idx_e: identifies which hitbox/feet point is being queried
//   - state_e: collision probe FSM states
//   - sext6: sign-extends a 6-bit step to 11 bits
//   - next_probe: probe walking order
// Configuration macro: PROBE_MID_EN inserts the left-mid/right-mid probes after BR.
package level_pkg;

  localparam int ROW_MAX    = 14;
  localparam int COL_MAX    = 19;
  localparam int LEFT       = 144;
  localparam int TOP        = 35;
  localparam int TILE_SHIFT = 5;

  typedef enum logic [2:0] {
    P_TL = 3'd0,
    P_TR = 3'd1,
    P_BL = 3'd2,
    P_BR = 3'd3,
    P_FL = 3'd4,
    P_FR = 3'd5,
    P_ML = 3'd6,
    P_MR = 3'd7
  } probe_idx_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [10:0] sext6(input logic [5:0] v);
    return {{5{v[5]}}, v};
  endfunction

  // Walking order: corners, optional mid probes, then the two feet. FR is always last.
  function automatic probe_idx_e next_probe(input probe_idx_e p);
    probe_idx_e n;
    n = P_FR;
    case (p)
      P_TL: n = P_TR;
      P_TR: n = P_BL;
      P_BL: n = P_BR;
`ifdef PROBE_MID_EN
      P_BR: n = P_ML;
      P_ML: n = P_MR;
      P_MR: n = P_FL;
`else
      P_BR: n = P_FL;
`endif
      P_FL: n = P_FR;
      default: n = P_FR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// probe_addr_gen: combinational probe coordinate generator.
// Ports:
//   idx            probe index (which corner / mid / foot point)
//   nx, ny         latched proposed top-left, 11-bit signed
//   px, py         latched current top-left, unsigned screen pixels
//   probe_x/_y     11-bit probe coordinate (bit10 set = negative)
//   neg_x, neg_y   per-axis negative flags
//   neg            either axis negative
module probe_addr_gen
  import level_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 32
) (
  input  probe_idx_e  idx,
  input  logic [10:0] nx,
  input  logic [10:0] ny,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  output logic [10:0] probe_x,
  output logic [10:0] probe_y,
  output logic        neg_x,
  output logic        neg_y,
  output logic        neg
);

  localparam logic [10:0] W_M1   = 11'(W - 1);
  localparam logic [10:0] H_M1   = 11'(H - 1);
  localparam logic [10:0] H_FULL = 11'(H);
  localparam logic [10:0] H_HALF = 11'(H >> 1);

  // Select base point and offset for the requested probe.
  always_comb begin
    probe_x = nx;
    probe_y = ny;
    case (idx)
      P_TL: begin probe_x = nx;                 probe_y = ny;                   end
      P_TR: begin probe_x = nx + W_M1;          probe_y = ny;                   end
      P_BL: begin probe_x = nx;                 probe_y = ny + H_M1;            end
      P_BR: begin probe_x = nx + W_M1;          probe_y = ny + H_M1;            end
      P_FL: begin probe_x = {1'b0, px};         probe_y = {1'b0, py} + H_FULL;  end
      P_FR: begin probe_x = {1'b0, px} + W_M1;  probe_y = {1'b0, py} + H_FULL;  end
      P_ML: begin probe_x = nx;                 probe_y = ny + H_HALF;          end
      P_MR: begin probe_x = nx + W_M1;          probe_y = ny + H_HALF;          end
      default: begin probe_x = nx;              probe_y = ny;                   end
    endcase
  end

  assign neg_x = probe_x[10];
  assign neg_y = probe_y[10];
  assign neg   = neg_x | neg_y;

endmodule

// File: rtl/collision_probe.sv
// collision_probe: walks the hitbox corners of a proposed move plus two feet
// probes against the level's combinational collision port, one query per cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request pulse, only honoured in IDLE
//   px, py, dx, dy    current position and signed proposed step (latched at start)
//   q_x, q_y, q_data  registered query address / level response (1 = solid/off-map)
//   busy, done        probing in progress / one-cycle completion pulse
//   hit, blocked      proposed-box corner hits {BR,BL,TR,TL} and their OR
//   on_ground         solid under the current feet
// Configuration macro: PROBE_MID_EN adds left-mid/right-mid probes (8 probes, done at N+9).
module collision_probe
  import level_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [5:0] dx,
  input  logic [5:0] dy,
  output logic [9:0] q_x,
  output logic [9:0] q_y,
  input  logic       q_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] hit,
  output logic       on_ground,
  output logic       blocked
);

  state_e      state_r, state_s;
  probe_idx_e  k_r, gen_idx_s;
  logic [10:0] nx_r, ny_r, gen_nx_s, gen_ny_s, gen_x_s, gen_y_s;
  logic [9:0]  px_r, py_r, gen_px_s, gen_py_s;
  logic        gen_neg_x_s, gen_neg_y_s, gen_neg_s;
  logic        q_neg_r, last_s, sample_s;
  logic [7:0]  shadow_r, sh_next_s;
  logic [3:0]  hit_s;

  // Address generator inputs: in IDLE the first probe is computed from the live
  // ports so q_x/q_y are valid the cycle after start; otherwise the next probe.
  always_comb begin
    gen_idx_s = P_TL;
    gen_nx_s  = nx_r;
    gen_ny_s  = ny_r;
    gen_px_s  = px_r;
    gen_py_s  = py_r;
    if (state_r == IDLE) begin
      gen_idx_s = P_TL;
      gen_nx_s  = {1'b0, px} + sext6(dx);
      gen_ny_s  = {1'b0, py} + sext6(dy);
      gen_px_s  = px;
      gen_py_s  = py;
    end else begin
      gen_idx_s = next_probe(k_r);
    end
  end

  probe_addr_gen #(.W(W), .H(H)) u_addr (
    .idx     (gen_idx_s),
    .nx      (gen_nx_s),
    .ny      (gen_ny_s),
    .px      (gen_px_s),
    .py      (gen_py_s),
    .probe_x (gen_x_s),
    .probe_y (gen_y_s),
    .neg_x   (gen_neg_x_s),
    .neg_y   (gen_neg_y_s),
    .neg     (gen_neg_s)
  );

  // Next-state logic and shadow/hit combination.
  always_comb begin
    state_s   = state_r;
    last_s    = (k_r == P_FR);
    // A negative probe was clamped to 0 on the port, so its response is meaningless.
    sample_s  = q_data | q_neg_r;
    sh_next_s = shadow_r;
    sh_next_s[k_r] = sample_s;
`ifdef PROBE_MID_EN
    hit_s = {sh_next_s[3] | sh_next_s[7], sh_next_s[2] | sh_next_s[6],
             sh_next_s[1] | sh_next_s[7], sh_next_s[0] | sh_next_s[6]};
`else
    hit_s = sh_next_s[3:0];
`endif
    case (state_r)
      IDLE: begin
        if (start) state_s = PROBE;
        else       state_s = IDLE;
      end
      PROBE: begin
        if (last_s) state_s = DONE;
        else        state_s = PROBE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath: latches, query address, shadow accumulator and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx_r      <= 11'd0;
      ny_r      <= 11'd0;
      px_r      <= 10'd0;
      py_r      <= 10'd0;
      k_r       <= P_TL;
      q_neg_r   <= 1'b0;
      shadow_r  <= 8'd0;
      q_x       <= 10'd0;
      q_y       <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 4'd0;
      on_ground <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            nx_r     <= gen_nx_s;
            ny_r     <= gen_ny_s;
            px_r     <= px;
            py_r     <= py;
            k_r      <= P_TL;
            shadow_r <= 8'd0;
            q_x      <= gen_neg_x_s ? 10'd0 : gen_x_s[9:0];
            q_y      <= gen_neg_y_s ? 10'd0 : gen_y_s[9:0];
            q_neg_r  <= gen_neg_s;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        PROBE: begin
          shadow_r <= sh_next_s;
          if (last_s) begin
            hit       <= hit_s;
            blocked   <= |hit_s;
            on_ground <= sh_next_s[P_FL] | sh_next_s[P_FR];
            done      <= 1'b1;
          end else begin
            k_r     <= gen_idx_s;
            q_x     <= gen_neg_x_s ? 10'd0 : gen_x_s[9:0];
            q_y     <= gen_neg_y_s ? 10'd0 : gen_y_s[9:0];
            q_neg_r <= gen_neg_s;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_probe.sv
// tb_collision_probe: scoreboard bench for collision_probe with a behavioural
// tile-map model driving q_data. Honours PROBE_MID_EN for probe count/order.
module tb_collision_probe;
  import level_pkg::*;

  localparam int W = 32;
  localparam int H = 32;
`ifdef PROBE_MID_EN
  localparam int NP = 8;
`else
  localparam int NP = 6;
`endif

  typedef struct {
    int x;
    int y;
  } coord_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] px = 10'd0, py = 10'd0;
  logic [5:0] dx = 6'd0, dy = 6'd0;
  logic [9:0] q_x, q_y;
  logic       q_data;
  logic       busy, done, on_ground, blocked;
  logic [3:0] hit;

  logic [299:0] map_bits = '0;
  bit           force_zero = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  coord_t       cq[$];
  logic [4:0]   rq[$];

  collision_probe #(.W(W), .H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .px        (px),
    .py        (py),
    .dx        (dx),
    .dy        (dy),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_data    (q_data),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .on_ground (on_ground),
    .blocked   (blocked)
  );

  always #5 clk = ~clk;

  function automatic bit map_at(input logic [299:0] m, input int x, input int y);
    int col, row;
    if (x < LEFT || y < TOP) return 1'b1;
    col = (x - LEFT) / 32;
    row = (y - TOP) / 32;
    if (col > COL_MAX || row > ROW_MAX) return 1'b1;
    return m[row * 20 + col];
  endfunction

  assign q_data = force_zero ? 1'b0 : map_at(map_bits, int'(q_x), int'(q_y));

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int row, input int col);
    map_bits[row * 20 + col] = 1'b1;
  endtask

  // Independent model: list probe points in walking order, push the expected
  // query coordinates and the final {on_ground, hit}.
  task automatic build_expect(input int pxi, input int pyi, input int dxi, input int dyi);
    int nx, ny;
    int xs[NP];
    int ys[NP];
    logic [3:0] mask[NP];
    logic [3:0] h;
    bit g, solid;
    coord_t c;
    nx = pxi + dxi;
    ny = pyi + dyi;
    xs[0] = nx;         ys[0] = ny;         mask[0] = 4'b0001;
    xs[1] = nx + W - 1; ys[1] = ny;         mask[1] = 4'b0010;
    xs[2] = nx;         ys[2] = ny + H - 1; mask[2] = 4'b0100;
    xs[3] = nx + W - 1; ys[3] = ny + H - 1; mask[3] = 4'b1000;
`ifdef PROBE_MID_EN
    xs[4] = nx;         ys[4] = ny + H / 2; mask[4] = 4'b0101;
    xs[5] = nx + W - 1; ys[5] = ny + H / 2; mask[5] = 4'b1010;
`endif
    xs[NP-2] = pxi;         ys[NP-2] = pyi + H; mask[NP-2] = 4'b0000;
    xs[NP-1] = pxi + W - 1; ys[NP-1] = pyi + H; mask[NP-1] = 4'b0000;
    h = 4'b0000;
    g = 1'b0;
    for (int i = 0; i < NP; i++) begin
      solid = (xs[i] < 0) || (ys[i] < 0) || (!force_zero && map_at(map_bits, xs[i], ys[i]));
      c.x = (xs[i] < 0) ? 0 : xs[i];
      c.y = (ys[i] < 0) ? 0 : ys[i];
      cq.push_back(c);
      if (mask[i] != 4'b0000) begin
        if (solid) h = h | mask[i];
      end else if (solid) begin
        g = 1'b1;
      end
    end
    rq.push_back({g, h});
  endtask

  // One transaction: optional start re-pulse at probe cycle `repulse`, optional
  // start held during the done cycle. Inputs are scrambled while busy.
  task automatic run_txn(input int pxi, input int pyi, input int dxi, input int dyi,
                         input int repulse, input bit start_in_done);
    coord_t c;
    logic [4:0] r;
    int cnt0;
    build_expect(pxi, pyi, dxi, dyi);
    @(negedge clk);
    px = 10'(pxi); py = 10'(pyi); dx = 6'(dxi); dy = 6'(dyi);
    start = 1'b1;
    cnt0 = done_cnt;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      start = (i == repulse) ? 1'b1 : 1'b0;
      px = 10'($urandom); py = 10'($urandom); dx = 6'($urandom); dy = 6'($urandom);
      c = cq.pop_front();
      check($sformatf("q_x[%0d]", i), 32'(q_x), 32'(c.x));
      check($sformatf("q_y[%0d]", i), 32'(q_y), 32'(c.y));
      check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("done_early[%0d]", i), 32'(done), 32'd0);
      @(negedge clk);
    end
    start = start_in_done;
    r = rq.pop_front();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("hit", 32'(hit), 32'(r[3:0]));
    check("blocked", 32'(blocked), 32'(|r[3:0]));
    check("on_ground", 32'(on_ground), 32'(r[4]));
    @(negedge clk);
    start = 1'b0;
    check("done_cleared", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hit_hold", 32'(hit), 32'(r[3:0]));
    check("done_count", 32'(done_cnt - cnt0), 32'd1);
  endtask

  initial begin
    int cnt0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q_x", 32'(q_x), 32'd0);
    check("rst_q_y", 32'(q_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_ground", 32'(on_ground), 32'd0);
    check("rst_blocked", 32'(blocked), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Open box, floor under the feet.
    set_tile(2, 1);
    run_txn(176, 67, 0, 0, -1, 1'b0);
    // Right wall.
    set_tile(1, 2);
    run_txn(176, 67, 1, 0, -1, 1'b0);
    // Start re-pulsed at N+3 and held in the done cycle: both ignored.
    run_txn(176, 67, 1, 0, 2, 1'b1);
    // Off-map left.
    map_bits = '0;
    run_txn(144, 67, -1, 0, -1, 1'b0);
    // Negative clamps with the level answering 0 everywhere.
    force_zero = 1'b1;
    run_txn(0, 67, -1, 0, -1, 1'b0);
    run_txn(300, 0, 0, -5, -1, 1'b0);
    force_zero = 1'b0;

    // Reset mid-probe: immediate clear, no done.
    @(negedge clk);
    px = 10'd176; py = 10'd67; dx = 6'd0; dy = 6'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cnt0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hit", 32'(hit), 32'd0);
    check("mid_rst_blocked", 32'(blocked), 32'd0);
    check("mid_rst_q_x", 32'(q_x), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - cnt0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    // Randomised maps and moves inside the non-overflowing range.
    for (int t = 0; t < 12; t++) begin
      for (int b = 0; b < 300; b++) map_bits[b] = ($urandom_range(0, 3) == 0);
      run_txn($urandom_range(0, 900), $urandom_range(0, 900),
              $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
